// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle main controller sequencing fetch/decode/execute for the ARM-subset core
// Inputs : clk, reset (async active-low), Op/Funct/Rd from the instruction register, mem_ready handshake
// Outputs: fetch strobes (IRWrite, NextPC), datapath selects (AdrSrc, ALUSrcA/B, ResultSrc, ImmSrc, RegSrc),
//          ALUControl, unconditional write requests (PCS, RegW, MemW, FlagW), illegal_instr pulse, state_o debug
module mc_control_unit #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       illegal_instr,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;
  state_t r_state, w_next;
  logic [3:0] w_cmd;
  logic w_rdy, w_cmd_ok, w_alu_op, w_irw, w_regw, w_memw, w_branch, w_ill;
  assign w_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign w_cmd = Funct[4:1];
  assign w_cmd_ok = (w_cmd == 4'b0100) | (w_cmd == 4'b0010) | (w_cmd == 4'b0000) | (w_cmd == 4'b1100);
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_FETCH;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_irw = 1'b0;
    w_regw = 1'b0;
    w_memw = 1'b0;
    w_branch = 1'b0;
    w_ill = 1'b0;
    w_alu_op = 1'b0;
    AdrSrc = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ResultSrc = 2'b00;
    case (r_state)
      S_FETCH: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        w_irw = w_rdy;
        w_next = w_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        w_ill = (Op == 2'b11);
        w_next = (Op == 2'b01) ? S_MEMADR :
                 (Op == 2'b00) ? (Funct[5] ? S_EXECI : S_EXECR) :
                 (Op == 2'b10) ? S_BRANCH : S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        w_next = w_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_regw = 1'b1;
        w_next = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        w_memw = 1'b1;
        w_next = w_rdy ? S_FETCH : S_MEMWR;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        w_alu_op = 1'b1;
        w_ill = ~w_cmd_ok;
        w_next = w_cmd_ok ? S_ALUWB : S_FETCH;
      end
      S_ALUWB: begin
        w_regw = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB = 2'b01;
        ResultSrc = 2'b10;
        w_branch = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end
  assign ALUControl = !w_alu_op ? 2'b00 :
                      (w_cmd == 4'b0010) ? 2'b01 :
                      (w_cmd == 4'b0000) ? 2'b10 :
                      (w_cmd == 4'b1100) ? 2'b11 : 2'b00;
  // Unsupported commands must not update flags, so FlagW is qualified by w_cmd_ok.
  assign FlagW = (reset & w_alu_op & w_cmd_ok) ?
                 {Funct[0], Funct[0] & ((w_cmd == 4'b0100) | (w_cmd == 4'b0010))} : 2'b00;
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};
  // Write requests are forced low while reset is held, even though FETCH is decoded.
  assign IRWrite = reset & w_irw;
  assign NextPC = reset & w_irw;
  assign RegW = reset & w_regw;
  assign MemW = reset & w_memw;
  assign illegal_instr = reset & w_ill;
  assign PCS = reset & (w_branch | (w_regw & (Rd == 4'hF)));
  assign state_o = r_state;
endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle main controller for the ARM-subset processor; sequences fetch/decode/execute over the shared ALU and memory port.
- Produces the unconditional write requests PCS, RegW, MemW and FlagW. The conditional-logic stage gates these with CondEx.
- Also produces the datapath mux selects, ALUControl and fetch strobes.
- Stalls on a memory ready handshake.

Parameters:
MEM_WAIT_EN, 1, 1: memory states wait for mem_ready; 0: mem_ready is ignored and treated as 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
Op  in  2  Instr[27:26]; 00 data-processing, 01 memory, 10 branch, 11 illegal
Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (data-processing) or L (memory)
Rd  in  4  Instr[15:12]
mem_ready  in  1  memory access completes this cycle
IRWrite  out  1  load instruction register
NextPC  out  1  PC+4 update request
AdrSrc  out  1  0 = PC, 1 = ALU result
ALUSrcA  out  1  0 = RD1, 1 = PC
ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ImmSrc  out  2  equals Op
RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
PCS  out  1  Branch | (RegW & Rd==4'hF)
RegW  out  1  register write request
MemW  out  1  memory write request
FlagW  out  2  [1] = NZ update, [0] = CV update
illegal_instr  out  1  one-cycle pulse on unsupported encoding
state_o  out  4  current state, for debug

Behaviour:
- State register: 4 bits.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Codes 10–15 are unreachable and go to FETCH on the next clock.
- reset low: state goes to FETCH immediately. While reset is low, IRWrite, NextPC, RegW, MemW, PCS, FlagW and illegal_instr are all 0.
- Reset released: the first FETCH cycle follows on the next edge.
- Outputs are Moore, decoded from state, except:
  - the mem_ready qualification;
  - ALUControl/FlagW, which are decoded from Funct;
  - ImmSrc, RegSrc and PCS.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10.
  - IRWrite = NextPC = mem_ready.
  - Stay while mem_ready=0; go to DECODE when it is 1.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - Next state by Op: 01 → MEMADR; 00 with I=0 → EXECR; 00 with I=1 → EXECI; 10 → BRANCH.
  - Op=11: pulse illegal_instr, go to FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Next: L=1 → MEMRD, L=0 → MEMWR.
- MEMRD: AdrSrc=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Go to FETCH.
- MEMWR:
  - AdrSrc=1, MemW=1, held for every wait cycle.
  - Go to FETCH on mem_ready.
  - MemW is deasserted in the cycle after acceptance.
- EXECR / EXECI:
  - ALUSrcA=0, ALUOp=1; ALUSrcB=00 (EXECR) or 01 (EXECI).
  - Supported cmd goes to ALUWB.
  - Unsupported cmd (anything other than 0100/0010/0000/1100): pulse illegal_instr, set FlagW=00, go to FETCH. ALUWB is skipped, so there is no RegW.
- ALUWB: ResultSrc=00, RegW=1. Go to FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1. Go to FETCH.
- ALU decode:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1:
    - cmd 0100 → 00; 0010 → 01; 0000 → 10; 1100 → 11.
    - FlagW[1] = S.
    - FlagW[0] = S & (cmd is ADD or SUB).
- With MEM_WAIT_EN=0: FETCH, MEMRD and MEMWR are each exactly 1 cycle.
- Latency with mem_ready tied 1:
  - data-processing 4 cycles;
  - LDR 5;
  - STR 4;
  - branch 3;
  - illegal Op 2.
- Op/Funct/Rd must be stable from DECODE until return to FETCH, because they come from the instruction register.
- In FETCH the inputs are don't-care except for ImmSrc/RegSrc/PCS, which are still combinational.
- PCS is valid only in ALUWB, MEMWB and BRANCH. In all other states it is 0, because RegW and Branch are 0 there.

Test Plan:
- Reset mid-MEMWR: reset low with MemW=1 → MemW=0 and state_o=0 combinationally; after release, FETCH with IRWrite = mem_ready.
- ADDS R1,R2,R3 (Op=00, Funct=001001), mem_ready=1:
  - state sequence 0 → 1 → 6 → 8 → 0;
  - in EXECR: ALUControl=00, FlagW=11;
  - in ALUWB: RegW=1, PCS=0.
- LDR (Op=01, Funct=011001) with mem_ready low for 3 cycles in MEMRD:
  - sequence 0 → 1 → 2 → 3 → 3 → 3 → 3 → 4 → 0;
  - AdrSrc=1 throughout MEMRD; RegW=1 only in MEMWB.
- STR with mem_ready low for 2 cycles:
  - MemW=1 for exactly 3 cycles in MEMWR, then FETCH;
  - STR stalled 2 cycles in FETCH: IRWrite=0 until mem_ready.
- Branch (Op=10): sequence 0 → 1 → 9 → 0, with PCS=1 and ResultSrc=10 in BRANCH. Also ORR to Rd=15: PCS=1 in ALUWB.
- Illegal encodings:
  - Op=11: illegal_instr=1 for one DECODE cycle, then FETCH.
  - cmd=1010 with S=1: illegal_instr in EXECR, FlagW=00, no ALUWB, RegW never 1.
